// File: rtl/mmio_console_pkg.sv
// mmio_console_pkg
//   Shared definitions for the memory-mapped console peripheral: register
//   offsets inside the 3-register window, STATUS/CTRL bit positions, the
//   register-select enum and the offset decoder used by the top level.
package mmio_console_pkg;

  // Byte offsets of the registers relative to BASE_ADDR
  localparam logic [3:0] CONSOLE_DATA   = 4'h0;
  localparam logic [3:0] CONSOLE_STATUS = 4'h4;
  localparam logic [3:0] CONSOLE_CTRL   = 4'h8;

  // STATUS bit positions
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_CLR_OVF_BIT = 0;
  localparam int CTRL_FLUSH_BIT   = 1;
  localparam int CTRL_TXEN_BIT    = 2;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_STATUS,
    REG_CTRL
  } regSel_e;

  // Maps the low offset nibble to a register; anything that is not one of
  // the three word-aligned offsets selects nothing.
  function automatic regSel_e decodeOffset(input logic [3:0] off);
    regSel_e sel;
    case (off)
      CONSOLE_DATA:   sel = REG_DATA;
      CONSOLE_STATUS: sel = REG_STATUS;
      CONSOLE_CTRL:   sel = REG_CTRL;
      default:        sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// mmio_console_sync_fifo
//   Synchronous FIFO holding console characters waiting to be transmitted.
//   Ports:
//     clk, reset      clock and asynchronous active-low reset
//     push_i, wdata_i write one entry (caller guarantees room or a same-cycle pop)
//     pop_i           drop the head entry (caller guarantees not empty)
//     flush_i         discard everything; overrides push/pop this cycle
//     rdata_o         head entry (meaningless while empty)
//     full_o, empty_o, count_o  occupancy
//   Storage is deliberately not reset; only pointers and count are.
module mmio_console_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two; a flush
  // returns everything to the empty state and voids any pop.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + AW'(1);
      if (pop_i)  rdPtr_d = rdPtr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = mem[rdPtr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mmio_console.sv
// mmio_console
//   Memory-mapped console: decodes DATA/STATUS/CTRL in a small window on the
//   data bus, buffers written characters in a FIFO and drains them over a
//   valid/ready stream.
//   Ports:
//     clk, reset            clock and asynchronous active-low reset
//     bus_addr/wdata/we     data-bus request (one write per asserted cycle)
//     bus_sel               address hits a register in the window
//     bus_rdata             combinational read data, 0 when not selected
//     tx_data/valid/ready   outgoing character stream
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h1000_0000,
  parameter int              DEPTH     = 16,
  parameter int              DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   bus_addr,
  input  logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_we,
  output logic              bus_sel,
  output logic [XLEN-1:0]   bus_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] offset;
  regSel_e         regSel;
  logic            dataWr, ctrlWr, flushReq, popReq, pushOk;
  logic            fifoFull, fifoEmpty;
  logic [CW-1:0]   fifoCount;
  logic            txEn_q, txEn_d;
  logic            overflow_q, overflow_d;
  logic            unusedWdata;

  // The window is only 12 bytes, so every bit above the nibble must be zero
  // after subtracting the base; misaligned offsets decode to REG_NONE.
  assign offset  = bus_addr - BASE_ADDR;
  assign regSel  = (offset[XLEN-1:4] == '0) ? decodeOffset(offset[3:0]) : REG_NONE;
  assign bus_sel = (regSel != REG_NONE);

  assign dataWr   = bus_we && (regSel == REG_DATA);
  assign ctrlWr   = bus_we && (regSel == REG_CTRL);
  assign flushReq = ctrlWr && bus_wdata[CTRL_FLUSH_BIT];

  // A pop in the same cycle as a flush is void; a push into a full FIFO is
  // only accepted when the head leaves in the same cycle.
  assign tx_valid = !fifoEmpty && txEn_q;
  assign popReq   = tx_valid && tx_ready && !flushReq;
  assign pushOk   = dataWr && (!fifoFull || popReq);

  // CTRL is a full-register write, so tx_en follows bit 2 on every CTRL
  // write; overflow is sticky until explicitly cleared.
  always_comb begin
    txEn_d     = txEn_q;
    overflow_d = overflow_q;
    if (ctrlWr) begin
      txEn_d = bus_wdata[CTRL_TXEN_BIT];
      if (bus_wdata[CTRL_CLR_OVF_BIT]) overflow_d = 1'b0;
    end
    if (dataWr && fifoFull && !popReq) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txEn_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      txEn_q     <= txEn_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (regSel)
      REG_STATUS: begin
        bus_rdata[STATUS_EMPTY_BIT] = fifoEmpty;
        bus_rdata[STATUS_FULL_BIT]  = fifoFull;
        bus_rdata[STATUS_OVF_BIT]   = overflow_q;
        bus_rdata[STATUS_COUNT_LSB +: 8] = 8'(fifoCount);
      end
      REG_CTRL: bus_rdata[CTRL_TXEN_BIT] = txEn_q;
      default: bus_rdata = '0;
    endcase
  end

  assign unusedWdata = ^bus_wdata;

  mmio_console_sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(DATA_W)
  ) txFifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (pushOk),
    .pop_i  (popReq),
    .flush_i(flushReq),
    .wdata_i(bus_wdata[DATA_W-1:0]),
    .rdata_o(tx_data),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .count_o(fifoCount)
  );

endmodule
